ray_sphere_intersect: RTL and testbench

//  Downstream of the sphere register stage: tests one ray against one sphere (center, radius, color)
//  and returns hit flag, hit distance t and sphere color. Multi-cycle, fixed-point 16.16, one job at a time.

---
 rtl/ray_pkg.sv | 77 +++++++
 rtl/fixed_sqrt.sv | 82 ++++++++
 rtl/ray_sphere_intersect.sv | 165 ++++++++++++++++
 tb/tb_ray_sphere_intersect.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types and saturating 16.16 fixed-point helpers for the ray/sphere datapath.
package ray_pkg;

    localparam int unsigned FRAC_BITS  = 16;
    localparam int unsigned FX_W       = 32;
    localparam int unsigned SQRT_ITERS = 24;
    localparam int unsigned COL_W      = 8;

    typedef logic signed [FX_W-1:0] fixed_real;
    typedef fixed_real [2:0] vector;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } color;

    localparam fixed_real FX_ONE = 32'sh0001_0000;
    localparam fixed_real FX_MAX = 32'sh7FFF_FFFF;
    localparam fixed_real FX_MIN = 32'sh8000_0001;
    localparam fixed_real T_EPS  = 32'sh0000_0040;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB,
        ST_DOT,
        ST_CHECK,
        ST_SQRT,
        ST_RESOLVE,
        ST_DONE
    } state_e;

    // Product bits [47:16], clamped symmetrically so saturation never wraps sign.
    function automatic fixed_real fx_mul(input fixed_real a, input fixed_real b);
        logic signed [63:0] p;
        logic signed [63:0] s;
        p = 64'(a) * 64'(b);
        s = p >>> FRAC_BITS;
        if (s > 64'(FX_MAX)) begin
            return FX_MAX;
        end else if (s < 64'(FX_MIN)) begin
            return FX_MIN;
        end
        return fixed_real'(32'(s));
    endfunction

    function automatic fixed_real fx_add_sat(input fixed_real a, input fixed_real b);
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        if (s > 33'(FX_MAX)) begin
            return FX_MAX;
        end else if (s < 33'(FX_MIN)) begin
            return FX_MIN;
        end
        return fixed_real'(32'(s));
    endfunction

    function automatic fixed_real fx_sub_sat(input fixed_real a, input fixed_real b);
        logic signed [32:0] s;
        s = 33'(a) - 33'(b);
        if (s > 33'(FX_MAX)) begin
            return FX_MAX;
        end else if (s < 33'(FX_MIN)) begin
            return FX_MIN;
        end
        return fixed_real'(32'(s));
    endfunction

    function automatic fixed_real fx_dot3(input vector a, input vector b);
        fixed_real acc;
        acc = fx_mul(a[0], b[0]);
        acc = fx_add_sat(acc, fx_mul(a[1], b[1]));
        acc = fx_add_sat(acc, fx_mul(a[2], b[2]));
        return acc;
    endfunction

endpackage

// File: rtl/fixed_sqrt.sv
// Restoring bit-serial integer square root; one result bit per cycle, first bit on the start edge.
module fixed_sqrt
    import ray_pkg::*;
#(
    parameter int unsigned ITERS = SQRT_ITERS
) (
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic               start_i,
    input  logic [2*ITERS-1:0] rad_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [ITERS-1:0]   root_o
);

    localparam int unsigned RW    = 2 * ITERS;
    localparam int unsigned REM_W = ITERS + 2;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    logic [RW-1:0]    rad_q,  rad_s,  rad_d;
    logic [REM_W-1:0] rem_q,  rem_s,  rem_d;
    logic [ITERS-1:0] root_q, root_s, root_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [REM_W-1:0] rem_t, trial_t;

    // One iteration, seeded from the operand on start so no cycle is spent loading.
    always_comb begin
        rad_s  = rad_q;
        rem_s  = rem_q;
        root_s = root_q;
        if (start_i) begin
            rad_s  = rad_i;
            rem_s  = '0;
            root_s = '0;
        end
        rem_t   = {rem_s[ITERS-1:0], rad_s[RW-1 -: 2]};
        trial_t = {root_s, 2'b01};
        rad_d   = {rad_s[RW-3:0], 2'b00};
        if (rem_t >= trial_t) begin
            rem_d  = rem_t - trial_t;
            root_d = {root_s[ITERS-2:0], 1'b1};
        end else begin
            rem_d  = rem_t;
            root_d = {root_s[ITERS-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rad_q  <= rad_d;
                rem_q  <= rem_d;
                root_q <= root_d;
                cnt_q  <= CNT_W'(ITERS - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rad_q  <= rad_d;
                rem_q  <= rem_d;
                root_q <= root_d;
                cnt_q  <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign root_o = root_q;

endmodule

// File: rtl/ray_sphere_intersect.sv
// Geometric ray/sphere test in 16.16 fixed point; one job in flight, result held until consumed.
module ray_sphere_intersect
    import ray_pkg::*;
(
    input  logic      CLOCK_50,
    input  logic      Reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  vector     ray_orig,
    input  vector     ray_dir,
    input  vector     sph_pos,
    input  fixed_real sph_rad,
    input  color      sph_col,
    output logic      out_valid,
    input  logic      out_ready,
    output logic      hit,
    output fixed_real hit_t,
    output color      hit_col
);

    state_e    state_q;
    logic      in_ready_q, out_valid_q, hit_q;
    fixed_real hit_t_q;
    color      hit_col_q;

    vector     orig_q, dir_q, cen_q, l_q, l_d;
    fixed_real rad_q, r2_q, r2_d, tca_q, tca_d, ll_q, ll_d;
    color      col_q;

    fixed_real tca2_c, d2_c, h_c, thc_c, t_near_c, t_far_c, res_t_c;
    logic      miss_c, res_hit_c, sqrt_start_c;
    logic      sqrt_busy, sqrt_done;
    logic [2*SQRT_ITERS-1:0] sqrt_rad_c;
    logic [SQRT_ITERS-1:0]   sqrt_root;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            l_d[i] = fx_sub_sat(cen_q[i], orig_q[i]);
        end
        r2_d  = fx_mul(rad_q, rad_q);
        tca_d = fx_dot3(l_q, dir_q);
        ll_d  = fx_dot3(l_q, l_q);

        tca2_c = fx_mul(tca_q, tca_q);
        d2_c   = fx_sub_sat(ll_q, tca2_c);
        h_c    = fx_sub_sat(r2_q, d2_c);
        // A saturated LL or h means the sphere is out of numeric range: never a hit.
        miss_c = (h_c < 0) || ((tca_q < 0) && (ll_q > r2_q))
              || (ll_q == FX_MAX) || (h_c == FX_MAX);

        sqrt_start_c = (state_q == ST_CHECK) && !miss_c && !sqrt_busy;
        sqrt_rad_c   = {h_c, {FRAC_BITS{1'b0}}};

        thc_c    = fixed_real'(FX_W'(sqrt_root));
        t_near_c = fx_sub_sat(tca_q, thc_c);
        t_far_c  = fx_add_sat(tca_q, thc_c);
        res_hit_c = 1'b0;
        res_t_c   = '0;
        if (t_near_c >= T_EPS) begin
            res_hit_c = 1'b1;
            res_t_c   = t_near_c;
        end else if (t_far_c >= T_EPS) begin
            res_hit_c = 1'b1;
            res_t_c   = t_far_c;
        end
    end

    fixed_sqrt #(
        .ITERS (SQRT_ITERS)
    ) u_sqrt (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .start_i  (sqrt_start_c),
        .rad_i    (sqrt_rad_c),
        .busy_o   (sqrt_busy),
        .done_o   (sqrt_done),
        .root_o   (sqrt_root)
    );

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_t_q     <= '0;
            hit_col_q   <= '0;
            orig_q      <= '0;
            dir_q       <= '0;
            cen_q       <= '0;
            rad_q       <= '0;
            col_q       <= '0;
            l_q         <= '0;
            r2_q        <= '0;
            tca_q       <= '0;
            ll_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        orig_q     <= ray_orig;
                        dir_q      <= ray_dir;
                        cen_q      <= sph_pos;
                        rad_q      <= sph_rad;
                        col_q      <= sph_col;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    l_q     <= l_d;
                    r2_q    <= r2_d;
                    state_q <= ST_DOT;
                end
                ST_DOT: begin
                    tca_q   <= tca_d;
                    ll_q    <= ll_d;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (miss_c) begin
                        out_valid_q <= 1'b1;
                        hit_q       <= 1'b0;
                        hit_t_q     <= '0;
                        hit_col_q   <= '0;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_SQRT;
                    end
                end
                ST_SQRT: begin
                    if (sqrt_done) begin
                        state_q <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    out_valid_q <= 1'b1;
                    hit_q       <= res_hit_c;
                    hit_t_q     <= res_t_c;
                    hit_col_q   <= res_hit_c ? col_q : '0;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign hit       = hit_q;
    assign hit_t     = hit_t_q;
    assign hit_col   = hit_col_q;

endmodule

// File: tb/tb_ray_sphere_intersect.sv
// Directed scoreboard bench for ray_sphere_intersect: results, latency, backpressure and reset abort.
module tb_ray_sphere_intersect;
    import ray_pkg::*;

    logic      CLOCK_50 = 1'b0;
    logic      Reset;
    logic      in_valid;
    logic      in_ready;
    vector     ray_orig, ray_dir, sph_pos;
    fixed_real sph_rad;
    color      sph_col;
    logic      out_valid;
    logic      out_ready;
    logic      hit;
    fixed_real hit_t;
    color      hit_col;

    typedef struct {
        logic        hit;
        fixed_real   t;
        color        col;
        int unsigned lat;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam fixed_real F0  = 32'sh0000_0000;
    localparam fixed_real F1  = 32'sh0001_0000;
    localparam fixed_real FH  = 32'sh0000_8000;
    localparam color      ORANGE = 24'hFF8000;
    localparam color      BLUE   = 24'h2040C0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ray_sphere_intersect dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ray_orig  (ray_orig),
        .ray_dir   (ray_dir),
        .sph_pos   (sph_pos),
        .sph_rad   (sph_rad),
        .sph_col   (sph_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hit       (hit),
        .hit_t     (hit_t),
        .hit_col   (hit_col)
    );

    function automatic vector mkv(input fixed_real x, input fixed_real y, input fixed_real z);
        vector v;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expected result, then present the job for exactly one accepting edge.
    task automatic drive(input vector o, input vector d, input vector c, input fixed_real r,
                         input color col, input logic ehit, input fixed_real et,
                         input int unsigned elat);
        exp_t e;
        e.hit = ehit;
        e.t   = et;
        e.col = ehit ? col : 24'h0;
        e.lat = elat;
        sb_q.push_back(e);
        @(negedge CLOCK_50);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        ray_orig = o;
        ray_dir  = d;
        sph_pos  = c;
        sph_rad  = r;
        sph_col  = col;
        in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid (bounded), compare against the scoreboard, optionally stall, then consume.
    task automatic collect(input string tag, input int unsigned hold);
        int unsigned lat;
        logic        seen;
        exp_t        e;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (i == 0) chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge CLOCK_50);
            lat++;
        end
        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_hit"}, 32'(hit), 32'(e.hit));
            chk({tag, "_hit_t"}, hit_t, e.t);
            chk({tag, "_hit_col"}, 32'(hit_col), 32'(e.col));
            for (int k = 0; k < int'(hold); k++) begin
                in_valid = 1'b1;
                @(negedge CLOCK_50);
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                chk({tag, "_hold_hit_t"}, hit_t, e.t);
                chk({tag, "_hold_col"}, 32'(hit_col), 32'(e.col));
            end
        end
        @(negedge CLOCK_50);
        out_ready = 1'b1;
        @(posedge CLOCK_50);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge CLOCK_50);
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t dropped;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ray_orig  = '0;
        ray_dir   = '0;
        sph_pos   = '0;
        sph_rad   = '0;
        sph_col   = '0;
        repeat (3) @(posedge CLOCK_50);
        #1 Reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_hit_t", hit_t, 32'd0);
        chk("rst_hit_col", 32'(hit_col), 32'd0);

        // Head-on hit at t=4.0
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, F0, 32'sh0005_0000), F1, ORANGE,
              1'b1, 32'sh0004_0000, 28);
        collect("front", 0);

        // Sphere behind the ray: early miss
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, F0, -32'sh0005_0000), F1, ORANGE,
              1'b0, 32'sh0, 3);
        collect("behind", 0);

        // Origin at centre: near root negative, far root used
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, F0, F0), 32'sh0002_0000, BLUE,
              1'b1, 32'sh0002_0000, 28);
        collect("inside", 0);

        // Grazing ray, h == 0
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F1, F0, 32'sh0005_0000), F1, ORANGE,
              1'b1, 32'sh0005_0000, 28);
        collect("tangent", 0);

        // Origin on the surface: t=0 rejected by the epsilon guard, exit point at 2.0
        drive(mkv(F0, F0, 32'sh0004_0000), mkv(F0, F0, F1), mkv(F0, F0, 32'sh0005_0000), F1,
              BLUE, 1'b1, 32'sh0002_0000, 28);
        collect("surface", 0);

        // Off-axis: h=0.75, thc=floor(sqrt(0xC000<<16))=0xDDB3, t=3.0-thc
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, FH, 32'sh0003_0000), F1, BLUE,
              1'b1, 32'sh0002_224D, 28);
        collect("offaxis", 0);

        // LL saturates: must resolve as a miss rather than a false hit
        drive(mkv(F0, F0, F0), mkv(F1, F0, F0), mkv(32'sh7530_0000, F0, F0), F1, ORANGE,
              1'b0, 32'sh0, 3);
        collect("saturate", 0);

        // Backpressure: result held for 10 cycles while in_valid is asserted
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, F0, 32'sh0005_0000), F1, ORANGE,
              1'b1, 32'sh0004_0000, 28);
        ray_orig = mkv(F0, F0, F0);
        sph_pos  = mkv(F0, F0, -32'sh0005_0000);
        collect("stall", 10);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK_50);
            chk("stall_no_extra_job", 32'(out_valid), 32'd0);
        end

        // Reset while the square root is running
        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, F0, 32'sh0005_0000), F1, ORANGE,
              1'b1, 32'sh0004_0000, 28);
        repeat (10) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        Reset = 1'b1;
        @(posedge CLOCK_50);
        #1 Reset = 1'b0;
        @(negedge CLOCK_50);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_hit_t", hit_t, 32'd0);
        if (sb_q.size() != 0) dropped = sb_q.pop_front();
        for (int k = 0; k < 30; k++) begin
            @(negedge CLOCK_50);
            chk("abort_no_pulse", 32'(out_valid), 32'd0);
        end

        drive(mkv(F0, F0, F0), mkv(F0, F0, F1), mkv(F0, F0, F0), 32'sh0002_0000, BLUE,
              1'b1, 32'sh0002_0000, 28);
        collect("after_abort", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
